// File: rtl/control_unit_if.sv
// Bus between the instruction sequencer and the register-file/ALU datapath.
// Latency: none, plain wires.
// Backpressure: none; run is the only request and is sampled only when idle.
interface control_unit_if;
   logic       run;
   logic [8:0] din;
   logic       imediate_select;
   logic       r0_select;
   logic       r1_select;
   logic       r2_select;
   logic       r3_select;
   logic       r4_select;
   logic       r5_select;
   logic       r6_select;
   logic       r7_select;
   logic       r_select;
   logic [7:0] r_load;
   logic       a_load;
   logic       g_load;
   logic [1:0] alu_op;
   logic       done;
   logic [8:0] ir;

   // Sequencer side: takes the start request and instruction, drives the controls.
   modport master (
      input  run, din,
      output imediate_select,
             r0_select, r1_select, r2_select, r3_select,
             r4_select, r5_select, r6_select, r7_select,
             r_select, r_load, a_load, g_load, alu_op, done, ir
   );

   // Datapath/requester side.
   modport slave (
      output run, din,
      input  imediate_select,
             r0_select, r1_select, r2_select, r3_select,
             r4_select, r5_select, r6_select, r7_select,
             r_select, r_load, a_load, g_load, alu_op, done, ir
   );
endinterface

// File: rtl/control_unit.sv
// Sequencer for a 9-bit III XXX YYY instruction set (mv, mvi, add, sub, and, or, nop).
// Latency: mv/mvi/nop finish 2 cycles after fetch edge's T0, ALU ops 4 cycles (T0..T3).
// Backpressure: run is sampled only in T0; run/din are ignored while an instruction runs.
module control_unit (
   input  logic          clock,
   input  logic          reset,
   control_unit_if.master bus
);

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;

   state_t     state;
   state_t     state_nxt;
   logic [8:0] ir_q;
   logic [2:0] opcode;
   logic [2:0] rx;
   logic [2:0] ry;
   logic [7:0] rx_onehot;
   logic [7:0] ry_onehot;
   logic       is_alu;

   // Combinational control outputs, gathered before fanning out to the bus.
   logic [7:0] sel;
   logic       imm_sel;
   logic       g_sel;
   logic [7:0] load;
   logic       a_ld;
   logic       g_ld;
   logic [1:0] op;
   logic       fin;

   assign opcode    = ir_q[8:6];
   assign rx        = ir_q[5:3];
   assign ry        = ir_q[2:0];
   assign rx_onehot = 8'd1 << rx;
   assign ry_onehot = 8'd1 << ry;
   assign is_alu    = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_AND) || (opcode == OP_OR);

   // State register; reset abandons any instruction in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= T0;
      end else begin
         state <= state_nxt;
      end
   end

   // Instruction register captures din only on an accepted fetch.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ir_q <= 9'd0;
      end else if ((state == T0) && bus.run) begin
         ir_q <= bus.din;
      end
   end

   // Next state and control decode from state and ir; everything idles low in T0.
   always_comb begin
      state_nxt = state;
      sel       = 8'd0;
      imm_sel   = 1'b0;
      g_sel     = 1'b0;
      load      = 8'd0;
      a_ld      = 1'b0;
      g_ld      = 1'b0;
      op        = 2'b00;
      fin       = 1'b0;
      case (state)
         T0: begin
            if (bus.run) state_nxt = T1;
         end
         T1: begin
            if (opcode == OP_MV) begin
               sel       = ry_onehot;
               load      = rx_onehot;
               fin       = 1'b1;
               state_nxt = T0;
            end else if (opcode == OP_MVI) begin
               imm_sel   = 1'b1;
               load      = rx_onehot;
               fin       = 1'b1;
               state_nxt = T0;
            end else if (is_alu) begin
               sel       = rx_onehot;
               a_ld      = 1'b1;
               state_nxt = T2;
            end else begin
               // 110/111 are nops: complete without touching the datapath.
               fin       = 1'b1;
               state_nxt = T0;
            end
         end
         T2: begin
            if (is_alu) begin
               sel  = ry_onehot;
               g_ld = 1'b1;
               case (opcode)
                  OP_SUB:  op = 2'b01;
                  OP_AND:  op = 2'b10;
                  OP_OR:   op = 2'b11;
                  default: op = 2'b00;
               endcase
               state_nxt = T3;
            end else begin
               state_nxt = T0;
            end
         end
         T3: begin
            g_sel     = 1'b1;
            load      = rx_onehot;
            fin       = 1'b1;
            state_nxt = T0;
         end
         default: state_nxt = T0;
      endcase
   end

   assign bus.r0_select       = sel[0];
   assign bus.r1_select       = sel[1];
   assign bus.r2_select       = sel[2];
   assign bus.r3_select       = sel[3];
   assign bus.r4_select       = sel[4];
   assign bus.r5_select       = sel[5];
   assign bus.r6_select       = sel[6];
   assign bus.r7_select       = sel[7];
   assign bus.imediate_select = imm_sel;
   assign bus.r_select        = g_sel;
   assign bus.r_load          = load;
   assign bus.a_load          = a_ld;
   assign bus.g_load          = g_ld;
   assign bus.alu_op          = op;
   assign bus.done            = fin;
   assign bus.ir              = ir_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: hand-computed control vectors per cycle.
// Inputs change and outputs are sampled on the falling clock edge.
// Reset is also exercised asynchronously between clock edges.
module tb_control_unit;

   logic clock;
   logic reset;
   int   n_cmp;
   int   n_bad;

   control_unit_if bus ();

   control_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   localparam logic [22:0] ZERO = 23'd0;

   // Packing order: imm, r_select, r7..r0 select, r_load, a_load, g_load, alu_op, done.
   function automatic logic [22:0] ev(input logic imm, input logic rs, input logic [7:0] s,
                                      input logic [7:0] l, input logic a, input logic g,
                                      input logic [1:0] op, input logic d);
      return {imm, rs, s, l, a, g, op, d};
   endfunction

   function automatic logic [22:0] observed();
      return {bus.imediate_select, bus.r_select,
              bus.r7_select, bus.r6_select, bus.r5_select, bus.r4_select,
              bus.r3_select, bus.r2_select, bus.r1_select, bus.r0_select,
              bus.r_load, bus.a_load, bus.g_load, bus.alu_op, bus.done};
   endfunction

   task automatic check(input string tag, input logic [22:0] exp_ctl, input logic [8:0] exp_ir);
      logic [22:0] got;
      got = observed();
      n_cmp++;
      assert (got === exp_ctl) else begin
         n_bad++;
         $error("FAIL %s ctl: got %06h want %06h", tag, got, exp_ctl);
      end
      n_cmp++;
      assert (bus.ir === exp_ir) else begin
         n_bad++;
         $error("FAIL %s ir: got %09b want %09b", tag, bus.ir, exp_ir);
      end
   endtask

   task automatic cyc();
      @(negedge clock);
   endtask

   // Present an instruction with run=1 for exactly one rising edge; returns in T1.
   task automatic fetch(input logic [8:0] word);
      bus.din = word;
      bus.run = 1'b1;
      cyc();
      bus.run = 1'b0;
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      reset   = 1'b0;
      bus.run = 1'b0;
      bus.din = 9'd0;

      // Reset asserted between edges must clear state and ir immediately.
      #1 reset = 1'b1;
      #1 check("reset_async", ZERO, 9'd0);
      cyc();
      check("reset_held", ZERO, 9'd0);
      bus.din = 9'b101_101_101;
      bus.run = 1'b0;
      reset   = 1'b0;

      // Idle with run low: nothing asserted, ir untouched.
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("idle_run0", ZERO, 9'd0);
      end

      // mv r2,r5
      fetch(9'b000_010_101);
      check("mv_t1", ev(0, 0, 8'h20, 8'h04, 0, 0, 2'b00, 1), 9'b000_010_101);
      cyc();
      check("mv_t0", ZERO, 9'b000_010_101);

      // mvi r7
      fetch(9'b001_111_000);
      check("mvi_t1", ev(1, 0, 8'h00, 8'h80, 0, 0, 2'b00, 1), 9'b001_111_000);
      cyc();
      check("mvi_t0", ZERO, 9'b001_111_000);

      // sub r1,r6
      fetch(9'b011_001_110);
      check("sub_t1", ev(0, 0, 8'h02, 8'h00, 1, 0, 2'b00, 0), 9'b011_001_110);
      cyc();
      check("sub_t2", ev(0, 0, 8'h40, 8'h00, 0, 1, 2'b01, 0), 9'b011_001_110);
      cyc();
      check("sub_t3", ev(0, 1, 8'h00, 8'h02, 0, 0, 2'b00, 1), 9'b011_001_110);
      cyc();
      check("sub_t0", ZERO, 9'b011_001_110);

      // and r4,r4: same register as both operands
      fetch(9'b100_100_100);
      check("and_t1", ev(0, 0, 8'h10, 8'h00, 1, 0, 2'b00, 0), 9'b100_100_100);
      cyc();
      check("and_t2", ev(0, 0, 8'h10, 8'h00, 0, 1, 2'b10, 0), 9'b100_100_100);
      cyc();
      check("and_t3", ev(0, 1, 8'h00, 8'h10, 0, 0, 2'b00, 1), 9'b100_100_100);
      cyc();
      check("and_t0", ZERO, 9'b100_100_100);

      // or r0,r7 with run held and din changed mid-instruction: both ignored until T0.
      bus.din = 9'b101_000_111;
      bus.run = 1'b1;
      cyc();
      bus.din = 9'b110_000_000;
      check("or_t1", ev(0, 0, 8'h01, 8'h00, 1, 0, 2'b00, 0), 9'b101_000_111);
      cyc();
      check("or_t2", ev(0, 0, 8'h80, 8'h00, 0, 1, 2'b11, 0), 9'b101_000_111);
      cyc();
      check("or_t3", ev(0, 1, 8'h00, 8'h01, 0, 0, 2'b00, 1), 9'b101_000_111);
      cyc();
      check("or_t0", ZERO, 9'b101_000_111);

      // run still high with nop: done every second cycle, nothing else.
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("nop_t1", ev(0, 0, 8'h00, 8'h00, 0, 0, 2'b00, 1), 9'b110_000_000);
         cyc();
         check("nop_t0", ZERO, 9'b110_000_000);
      end
      bus.run = 1'b0;

      // Opcode 111 is also a nop.
      fetch(9'b111_011_010);
      check("nop7_t1", ev(0, 0, 8'h00, 8'h00, 0, 0, 2'b00, 1), 9'b111_011_010);
      cyc();
      check("nop7_t0", ZERO, 9'b111_011_010);

      // add r0,r1 interrupted by reset in T2.
      fetch(9'b010_000_001);
      check("add_t1", ev(0, 0, 8'h01, 8'h00, 1, 0, 2'b00, 0), 9'b010_000_001);
      cyc();
      check("add_t2", ev(0, 0, 8'h02, 8'h00, 0, 1, 2'b00, 0), 9'b010_000_001);
      #2 reset = 1'b1;
      #1 check("rst_mid_async", ZERO, 9'd0);
      cyc();
      check("rst_mid_held", ZERO, 9'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("rst_mid_after", ZERO, 9'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
